// File: rtl/conv_encoder_tx.sv
// Systematic convolutional encoder, K=89, with optional differential
// precoding and puncturing to rate 1/2, 3/4 or 7/8 into 2-bit code pairs.
module conv_encoder_tx #(
  parameter logic [88:0] MASK_1_2 = 89'hD354E3267,
  parameter logic [88:0] MASK_3_4 = 89'h87AFC51E7688DDEE,
  parameter logic [88:0] MASK_7_8 = 89'o77663166177600720153763372136
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_code_rate,
  input  logic       i_diff_en,
  input  logic       i_vld,
  input  logic       i_data,
  output logic       o_rdy,
  output logic       o_vld,
  output logic [1:0] o_data,
  output logic       o_blk_start,
  input  logic       i_rdy
);

  localparam logic [1:0] RATE_3_4 = 2'd1;
  localparam logic [1:0] RATE_7_8 = 2'd2;

  logic [88:0] mask;
  logic [87:0] sr;
  logic [2:0]  phase;
  logic [2:0]  phase_last;
  logic        diff_en_r;
  logic        e_prev;
  logic        reset_d;

  // code-bit FIFO, slot 0 is the oldest bit
  logic [1:0]  cnt;
  logic [2:0]  fifo_d;
  logic [2:0]  fifo_f;

  logic [88:0] mask_sel;
  logic [2:0]  last_sel;
  logic [88:0] v;
  logic        e;
  logic        p;
  logic        acc;
  logic        pop;
  logic        two;
  logic [1:0]  base;
  logic [1:0]  push_n;
  logic [1:0]  cnt_next;
  logic [2:0]  q_d;
  logic [2:0]  q_f;
  logic [2:0]  nq_d;
  logic [2:0]  nq_f;

  always_comb begin
    mask_sel = MASK_1_2;
    last_sel = 3'd0;
    unique case (1'b1)
      (i_code_rate == RATE_3_4): begin
        mask_sel = MASK_3_4;
        last_sel = 3'd2;
      end
      (i_code_rate == RATE_7_8): begin
        mask_sel = MASK_7_8;
        last_sel = 3'd6;
      end
      default: begin
        mask_sel = MASK_1_2;
        last_sel = 3'd0;
      end
    endcase
  end

  assign o_vld = !reset & cnt[1];
  assign o_rdy = !reset & !reset_d & (!cnt[1] | i_rdy);
  assign o_data = o_vld ? {fifo_d[0], fifo_d[1]} : 2'b00;
  assign o_blk_start = o_vld & fifo_f[0];

  assign pop = o_vld & i_rdy;
  assign acc = i_vld & o_rdy;

  assign e = diff_en_r ? (i_data ^ e_prev) : i_data;
  assign v = {sr, e};
  assign p = ^(v & mask);
  // parity only rides along with the phase-0 systematic bit
  assign two = (phase == 3'd0);

  assign base = pop ? (cnt - 2'd2) : cnt;
  assign q_d = pop ? {2'b00, fifo_d[2]} : fifo_d;
  assign q_f = pop ? {2'b00, fifo_f[2]} : fifo_f;
  assign push_n = acc ? (two ? 2'd2 : 2'd1) : 2'd0;
  assign cnt_next = base + push_n;

  always_comb begin
    nq_d = q_d;
    nq_f = q_f;
    if (acc) begin
      unique case (1'b1)
        (base == 2'd0): begin
          nq_d[0] = e;
          nq_f[0] = two;
          if (two) begin
            nq_d[1] = p;
            nq_f[1] = 1'b0;
          end
        end
        (base == 2'd1): begin
          nq_d[1] = e;
          nq_f[1] = two;
          if (two) begin
            nq_d[2] = p;
            nq_f[2] = 1'b0;
          end
        end
        default: begin
          nq_d[2] = e;
          nq_f[2] = two;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    reset_d <= reset;
    if (reset) begin
      mask       <= mask_sel;
      phase_last <= last_sel;
      diff_en_r  <= i_diff_en;
      sr         <= '0;
      e_prev     <= 1'b0;
      phase      <= 3'd0;
      cnt        <= 2'd0;
      fifo_d     <= 3'd0;
      fifo_f     <= 3'd0;
    end else begin
      cnt    <= cnt_next;
      fifo_d <= nq_d;
      fifo_f <= nq_f;
      if (acc) begin
        sr     <= v[87:0];
        e_prev <= e;
        phase  <= (phase == phase_last) ? 3'd0 : phase + 3'd1;
      end
    end
  end

endmodule
